// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory alucodes, FSM states
// and the enable/disable levels used throughout the datapath.
package load_store_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment detection, store byte-lane
// replication with strobes, and load byte/half extraction with extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        misaligned,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{offset, 3'b000} +: 8];
  assign lane_half = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    is_mem     = DISABLE;
    is_load    = DISABLE;
    misaligned = DISABLE;
    wdata      = 32'h0;
    wstrb      = 4'b0000;
    ld_data    = rdata;
    case (op)
      ALU_LB: begin
        is_mem  = ENABLE;
        is_load = ENABLE;
        ld_data = {{24{lane_byte[7]}}, lane_byte};
      end
      ALU_LBU: begin
        is_mem  = ENABLE;
        is_load = ENABLE;
        ld_data = {24'h0, lane_byte};
      end
      ALU_LH: begin
        is_mem     = ENABLE;
        is_load    = ENABLE;
        misaligned = offset[0];
        ld_data    = {{16{lane_half[15]}}, lane_half};
      end
      ALU_LHU: begin
        is_mem     = ENABLE;
        is_load    = ENABLE;
        misaligned = offset[0];
        ld_data    = {16'h0, lane_half};
      end
      ALU_LW: begin
        is_mem     = ENABLE;
        is_load    = ENABLE;
        misaligned = (offset != 2'b00);
      end
      ALU_SB: begin
        is_mem = ENABLE;
        wdata  = {4{store_data[7:0]}};
        wstrb  = 4'b0001 << offset;
      end
      ALU_SH: begin
        is_mem     = ENABLE;
        misaligned = offset[0];
        wdata      = {2{store_data[15:0]}};
        wstrb      = offset[1] ? 4'b1100 : 4'b0011;
      end
      ALU_SW: begin
        is_mem     = ENABLE;
        misaligned = (offset != 2'b00);
        wdata      = store_data;
        wstrb      = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one req/ack transaction per accepted op, with a
// timeout, and returns extended load data to register writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        done,
  output logic        misalign_err,
  output logic        bus_err
);

  lsu_state_t       state;
  logic [5:0]       op_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt;

  logic [5:0]  align_op;
  logic [1:0]  align_off;
  logic        is_mem;
  logic        is_load;
  logic        misaligned;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic [31:0] ld_data;

  // One aligner serves both paths: live inputs while idle, latched op while busy.
  assign align_op  = (state == LSU_IDLE) ? alucode : op_q;
  assign align_off = (state == LSU_IDLE) ? addr[1:0] : off_q;
  assign ready_in  = (state == LSU_IDLE);

  lsu_align u_align (
    .op         (align_op),
    .offset     (align_off),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .misaligned (misaligned),
    .wdata      (fmt_wdata),
    .wstrb      (fmt_wstrb),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LSU_IDLE;
      op_q         <= 6'h0;
      off_q        <= 2'b00;
      rd_q         <= 5'h0;
      cnt          <= '0;
      mem_req      <= DISABLE;
      mem_we       <= DISABLE;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_wstrb    <= 4'b0000;
      wb_valid     <= DISABLE;
      wb_data      <= 32'h0;
      wb_rd        <= 5'h0;
      done         <= DISABLE;
      misalign_err <= DISABLE;
      bus_err      <= DISABLE;
    end else begin
      wb_valid     <= DISABLE;
      done         <= DISABLE;
      misalign_err <= DISABLE;
      bus_err      <= DISABLE;
      case (state)
        LSU_IDLE: begin
          if (valid_in && is_mem) begin
            if (misaligned) begin
              misalign_err <= ENABLE;
            end else begin
              op_q      <= alucode;
              off_q     <= addr[1:0];
              rd_q      <= rd_in;
              cnt       <= '0;
              mem_req   <= ENABLE;
              mem_we    <= ~is_load;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= fmt_wdata;
              mem_wstrb <= fmt_wstrb;
              state     <= LSU_BUSY;
            end
          end
        end
        LSU_BUSY: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            mem_req   <= DISABLE;
            mem_we    <= DISABLE;
            mem_wstrb <= 4'b0000;
            done      <= ENABLE;
            if (is_load) begin
              wb_valid <= ENABLE;
              wb_data  <= ld_data;
              wb_rd    <= rd_q;
            end
            state <= LSU_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req   <= DISABLE;
            mem_we    <= DISABLE;
            mem_wstrb <= 4'b0000;
            bus_err   <= ENABLE;
            state     <= LSU_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with TIMEOUT=8, plus
// hand-written sequences for timeout, back-to-back and mid-transaction reset.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [5:0]  alucode = 6'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd_in = 5'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        done;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int fails = 0;
  logic [31:0] last_wb = 32'h0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .alucode(alucode), .addr(addr), .store_data(store_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .done(done), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;
    logic        exp_mis;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_wb;
    logic [31:0] exp_wbdata;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    valid_in   = 1'b1;
    alucode    = op;
    addr       = a;
    store_data = sd;
    rd_in      = rd;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    checkOutput($sformatf("v%0d ready_before", idx), {31'h0, ready_in}, 32'h1);
    drive(v.op, v.addr, v.sdata, v.rd);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    if (v.exp_mis) begin
      checkOutput($sformatf("v%0d misalign_err", idx), {31'h0, misalign_err}, 32'h1);
      checkOutput($sformatf("v%0d no_req", idx), {31'h0, mem_req}, 32'h0);
      checkOutput($sformatf("v%0d ready_mis", idx), {31'h0, ready_in}, 32'h1);
      @(negedge clk);
      checkOutput($sformatf("v%0d misalign_pulse", idx), {31'h0, misalign_err}, 32'h0);
      checkOutput($sformatf("v%0d no_req2", idx), {31'h0, mem_req}, 32'h0);
    end else begin
      checkOutput($sformatf("v%0d mem_req", idx), {31'h0, mem_req}, 32'h1);
      checkOutput($sformatf("v%0d mem_we", idx), {31'h0, mem_we}, {31'h0, v.exp_we});
      checkOutput($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
      checkOutput($sformatf("v%0d mem_wstrb", idx), {28'h0, mem_wstrb}, {28'h0, v.exp_wstrb});
      if (v.exp_we)
        checkOutput($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
      for (int k = 0; k < v.delay; k++) begin
        @(negedge clk);
        checkOutput($sformatf("v%0d req_hold%0d", idx, k), {31'h0, mem_req}, 32'h1);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEADDEAD;
      checkOutput($sformatf("v%0d done", idx), {31'h0, done}, 32'h1);
      checkOutput($sformatf("v%0d wb_valid", idx), {31'h0, wb_valid}, {31'h0, v.exp_wb});
      checkOutput($sformatf("v%0d req_drop", idx), {31'h0, mem_req}, 32'h0);
      checkOutput($sformatf("v%0d bus_err", idx), {31'h0, bus_err}, 32'h0);
      checkOutput($sformatf("v%0d ready_after", idx), {31'h0, ready_in}, 32'h1);
      if (v.exp_wb) begin
        checkOutput($sformatf("v%0d wb_data", idx), wb_data, v.exp_wbdata);
        checkOutput($sformatf("v%0d wb_rd", idx), {27'h0, wb_rd}, {27'h0, v.rd});
        last_wb = v.exp_wbdata;
      end else begin
        checkOutput($sformatf("v%0d wb_hold", idx), wb_data, last_wb);
      end
      @(negedge clk);
      checkOutput($sformatf("v%0d done_pulse", idx), {31'h0, done}, 32'h0);
      checkOutput($sformatf("v%0d wb_pulse", idx), {31'h0, wb_valid}, 32'h0);
    end
  endtask

  initial begin
    int ncyc;
    //           op       addr          sdata         rd     rdata         dly mis we  exp_addr      exp_wdata     strb     wb  wbdata
    vecs[0]  = '{ALU_LB,  32'h00000103, 32'h0,        5'd5,  32'h80FF1234, 3, 1'b0, 1'b0, 32'h00000100, 32'h0,        4'b0000, 1'b1, 32'hFFFFFF80};
    vecs[1]  = '{ALU_SH,  32'h00000202, 32'h0000ABCD, 5'd0,  32'h0,        0, 1'b0, 1'b1, 32'h00000200, 32'hABCDABCD, 4'b1100, 1'b0, 32'h0};
    vecs[2]  = '{ALU_LW,  32'h00000101, 32'h0,        5'd3,  32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0};
    vecs[3]  = '{ALU_LHU, 32'h00000002, 32'h0,        5'd7,  32'h80017FFF, 0, 1'b0, 1'b0, 32'h00000000, 32'h0,        4'b0000, 1'b1, 32'h00008001};
    vecs[4]  = '{ALU_LH,  32'h00000010, 32'h0,        5'd9,  32'h12348000, 1, 1'b0, 1'b0, 32'h00000010, 32'h0,        4'b0000, 1'b1, 32'hFFFF8000};
    vecs[5]  = '{ALU_SB,  32'h00000021, 32'h123456A5, 5'd0,  32'h0,        2, 1'b0, 1'b1, 32'h00000020, 32'hA5A5A5A5, 4'b0010, 1'b0, 32'h0};
    vecs[6]  = '{ALU_SW,  32'h00000040, 32'hDEADBEEF, 5'd0,  32'h0,        0, 1'b0, 1'b1, 32'h00000040, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    vecs[7]  = '{ALU_LW,  32'h00000044, 32'h0,        5'd31, 32'hCAFEF00D, 1, 1'b0, 1'b0, 32'h00000044, 32'h0,        4'b0000, 1'b1, 32'hCAFEF00D};
    vecs[8]  = '{ALU_SH,  32'h00000033, 32'h0000BEEF, 5'd0,  32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0};
    vecs[9]  = '{ALU_LHU, 32'h00000031, 32'h0,        5'd2,  32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0};
    vecs[10] = '{ALU_LB,  32'h00000000, 32'h0,        5'd0,  32'h0000007F, 0, 1'b0, 1'b0, 32'h00000000, 32'h0,        4'b0000, 1'b1, 32'h0000007F};
    vecs[11] = '{ALU_SB,  32'h00000003, 32'h000000FF, 5'd0,  32'h0,        1, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1'b0, 32'h0};
    vecs[12] = '{ALU_LBU, 32'h00000301, 32'h0,        5'd4,  32'h0000C300, 0, 1'b0, 1'b0, 32'h00000300, 32'h0,        4'b0000, 1'b1, 32'h000000C3};
    // Ack lands in the final allowed request cycle: completion must win.
    vecs[13] = '{ALU_LW,  32'h00000050, 32'h0,        5'd6,  32'h11223344, TO-1, 1'b0, 1'b0, 32'h00000050, 32'h0,   4'b0000, 1'b1, 32'h11223344};

    repeat (2) @(negedge clk);
    checkOutput("reset mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset ready_in", {31'h0, ready_in}, 32'h1);
    checkOutput("reset wb_data", wb_data, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset pulses", {28'h0, done, wb_valid, misalign_err, bus_err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Non-memory alucode is ignored.
    @(negedge clk);
    drive(6'd1, 32'h00000101, 32'h0, 5'd1);
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("nonmem req", {31'h0, mem_req}, 32'h0);
    checkOutput("nonmem misalign", {31'h0, misalign_err}, 32'h0);
    checkOutput("nonmem ready", {31'h0, ready_in}, 32'h1);

    // Timeout: store with no ack.
    drive(ALU_SW, 32'h00000080, 32'h01020304, 5'd0);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    ncyc = 0;
    while (mem_req && ncyc < 20) begin
      ncyc++;
      @(negedge clk);
    end
    checkOutput("timeout req_cycles", ncyc, TO);
    checkOutput("timeout bus_err", {31'h0, bus_err}, 32'h1);
    checkOutput("timeout done", {31'h0, done}, 32'h0);
    checkOutput("timeout ready", {31'h0, ready_in}, 32'h1);
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("late_ack done", {31'h0, done}, 32'h0);
    checkOutput("late_ack wb_valid", {31'h0, wb_valid}, 32'h0);
    checkOutput("late_ack bus_err", {31'h0, bus_err}, 32'h0);
    checkOutput("late_ack wb_hold", wb_data, last_wb);

    // Back-to-back: LHU with zero-wait ack, LBU accepted on the ready cycle.
    drive(ALU_LHU, 32'h00000002, 32'h0, 5'd10);
    @(posedge clk);
    @(negedge clk);
    valid_in  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h80017FFF;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("b2b lhu wb_valid", {31'h0, wb_valid}, 32'h1);
    checkOutput("b2b lhu wb_data", wb_data, 32'h00008001);
    checkOutput("b2b ready", {31'h0, ready_in}, 32'h1);
    drive(ALU_LBU, 32'h00000003, 32'h0, 5'd11);
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("b2b lbu req", {31'h0, mem_req}, 32'h1);
    checkOutput("b2b lbu addr", mem_addr, 32'h00000000);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("b2b lbu wb_data", wb_data, 32'h00000080);
    checkOutput("b2b lbu wb_rd", {27'h0, wb_rd}, 32'd11);
    last_wb = 32'h00000080;

    // Reset in the middle of a transaction.
    @(negedge clk);
    drive(ALU_LW, 32'h00000060, 32'h0, 5'd12);
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("rst_mid req_before", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst_mid ready", {31'h0, ready_in}, 32'h1);
    checkOutput("rst_mid pulses", {28'h0, done, wb_valid, misalign_err, bus_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("post_rst wb_valid", {31'h0, wb_valid}, 32'h0);
    checkOutput("post_rst done", {31'h0, done}, 32'h0);
    checkOutput("post_rst req", {31'h0, mem_req}, 32'h0);
    checkOutput("post_rst wb_data", wb_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
